// File: rtl/matrix_show.sv
// Matrix display sequencer: picks one or all stored matrices from a UART selector byte
// and streams their elements row-major to a byte sender, with newline gaps between matrices.
module matrix_show #(
    parameter int MAX_ROWS           = 5,
    parameter int MAX_COLS           = 5,
    parameter int MAX_MATS           = 10,
    parameter int ERR_TIMEOUT_CYCLES = 300_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic [3:0]  mat_count,
    output logic [3:0]  rd_mat_id,
    output logic [2:0]  rd_row_idx,
    output logic [2:0]  rd_col_idx,
    input  logic [2:0]  rd_dims_r,
    input  logic [2:0]  rd_dims_c,
    input  logic [31:0] rd_data,
    output logic [31:0] sender_data,
    output logic        sender_start,
    output logic        sender_is_last_col,
    output logic        sender_newline_only,
    input  logic        sender_ready,
    input  logic        sender_done,
    input  logic        btn_exit,
    output logic        show_done,
    output logic        show_err
);
    localparam int            TW         = $clog2(ERR_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ERR_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    ROWS_LIM   = 3'(MAX_ROWS);
    localparam logic [2:0]    COLS_LIM   = 3'(MAX_COLS);
    localparam logic [3:0]    MATS_LIM   = 4'(MAX_MATS);

    typedef enum logic [3:0] {
        IDLE, GET_ID, CHECK, RD_ADDR, RD_WAIT, SEND, TX_WAIT,
        NEXT_ELEM, SEND_GAP, GAP_WAIT, ERROR, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    sel_q, sel_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic [3:0]    mat_q, mat_d;
    logic [3:0]    last_q, last_d;
    logic          single_q, single_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   data_q, data_d;

    logic count_ok, sel_all, sel_one, slot_ok;
    logic start_c, newline_c;

    // Out-of-range counts or dimensions are treated as unusable rather than trusted.
    assign count_ok = (mat_count <= MATS_LIM);
    assign sel_all  = (sel_q == 8'd0) && (mat_count != 4'd0) && count_ok;
    assign sel_one  = (sel_q != 8'd0) && (sel_q <= {4'd0, mat_count}) && count_ok;
    assign slot_ok  = (rd_dims_r != 3'd0) && (rd_dims_c != 3'd0) &&
                      (rd_dims_r <= ROWS_LIM) && (rd_dims_c <= COLS_LIM);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        row_d     = row_q;
        col_d     = col_q;
        mat_d     = mat_q;
        last_d    = last_q;
        single_d  = single_q;
        timer_d   = '0;
        data_d    = data_q;
        start_c   = 1'b0;
        newline_c = 1'b0;
        case (state_q)
            IDLE: begin
                row_d = 3'd0;
                col_d = 3'd0;
                mat_d = 4'd0;
                if (start_en) state_d = GET_ID;
            end
            GET_ID: begin
                if (btn_exit) begin
                    state_d = DONE;
                end else if (rx_done) begin
                    sel_d   = rx_data;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                row_d = 3'd0;
                col_d = 3'd0;
                if (sel_all) begin
                    single_d = 1'b0;
                    mat_d    = 4'd0;
                    last_d   = mat_count - 4'd1;
                    state_d  = RD_ADDR;
                end else if (sel_one) begin
                    single_d = 1'b1;
                    mat_d    = sel_q[3:0] - 4'd1;
                    last_d   = sel_q[3:0] - 4'd1;
                    state_d  = RD_ADDR;
                end else begin
                    state_d = ERROR;
                end
            end
            RD_ADDR: begin
                // Empty slots are skipped silently in show-all but are an error when asked for.
                if (slot_ok)             state_d = RD_WAIT;
                else if (single_q)       state_d = ERROR;
                else if (mat_q == last_q) state_d = GET_ID;
                else                     mat_d = mat_q + 4'd1;
            end
            RD_WAIT: begin
                data_d  = rd_data;
                state_d = SEND;
            end
            SEND: begin
                if (sender_ready) begin
                    start_c = 1'b1;
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (sender_done) state_d = NEXT_ELEM;
            end
            NEXT_ELEM: begin
                if (col_q < rd_dims_c - 3'd1) begin
                    col_d   = col_q + 3'd1;
                    state_d = RD_ADDR;
                end else begin
                    col_d = 3'd0;
                    if (row_q < rd_dims_r - 3'd1) begin
                        row_d   = row_q + 3'd1;
                        state_d = RD_ADDR;
                    end else begin
                        row_d = 3'd0;
                        if (mat_q == last_q) begin
                            state_d = GET_ID;
                        end else begin
                            mat_d   = mat_q + 4'd1;
                            state_d = SEND_GAP;
                        end
                    end
                end
            end
            SEND_GAP: begin
                if (sender_ready) begin
                    newline_c = 1'b1;
                    state_d   = GAP_WAIT;
                end
            end
            GAP_WAIT: begin
                if (sender_done) state_d = RD_ADDR;
            end
            ERROR: begin
                if (timer_q == TIMER_LAST) state_d = GET_ID;
                else                       timer_d = timer_q + 1'b1;
            end
            DONE: begin
                if (!start_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 8'd0;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            mat_q    <= 4'd0;
            last_q   <= 4'd0;
            single_q <= 1'b0;
            timer_q  <= '0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            row_q    <= row_d;
            col_q    <= col_d;
            mat_q    <= mat_d;
            last_q   <= last_d;
            single_q <= single_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
        end
    end

    assign rd_mat_id           = mat_q;
    assign rd_row_idx          = row_q;
    assign rd_col_idx          = col_q;
    assign sender_data         = data_q;
    assign sender_start        = start_c;
    assign sender_newline_only = newline_c;
    // Only meaningful while an element is being handed over.
    assign sender_is_last_col  = ((state_q == SEND) || (state_q == TX_WAIT)) &&
                                 (col_q == rd_dims_c - 3'd1);
    assign show_done           = (state_q == DONE);
    assign show_err            = (state_q == ERROR);

endmodule

// File: tb/tb_matrix_show.sv
// Directed bench for matrix_show: storage and byte-sender models plus a pulse log.
module tb_matrix_show;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_en;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [3:0]  mat_count;
    logic [3:0]  rd_mat_id;
    logic [2:0]  rd_row_idx, rd_col_idx;
    logic [2:0]  rd_dims_r, rd_dims_c;
    logic [31:0] rd_data;
    logic [31:0] sender_data;
    logic        sender_start, sender_is_last_col, sender_newline_only;
    logic        sender_ready;
    logic        sender_done;
    logic        btn_exit;
    logic        show_done, show_err;

    logic [2:0]  dims_r [16];
    logic [2:0]  dims_c [16];
    logic [31:0] mem    [400];

    logic [33:0] log_q [$];
    int          bad_pulse = 0;
    int          dly = 0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    matrix_show #(.ERR_TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_en(start_en),
        .rx_data(rx_data), .rx_done(rx_done), .mat_count(mat_count),
        .rd_mat_id(rd_mat_id), .rd_row_idx(rd_row_idx), .rd_col_idx(rd_col_idx),
        .rd_dims_r(rd_dims_r), .rd_dims_c(rd_dims_c), .rd_data(rd_data),
        .sender_data(sender_data), .sender_start(sender_start),
        .sender_is_last_col(sender_is_last_col), .sender_newline_only(sender_newline_only),
        .sender_ready(sender_ready), .sender_done(sender_done),
        .btn_exit(btn_exit), .show_done(show_done), .show_err(show_err)
    );

    always #5 clk = ~clk;

    assign rd_dims_r = dims_r[rd_mat_id];
    assign rd_dims_c = dims_c[rd_mat_id];

    always @(posedge clk) rd_data <= mem[int'(rd_mat_id) * 25 + int'(rd_row_idx) * 5 + int'(rd_col_idx)];

    // Sender model: done pulse three cycles after each start; logs every pulse.
    always @(posedge clk) begin
        sender_done <= 1'b0;
        if (dly != 0) begin
            if (dly == 1) sender_done <= 1'b1;
            dly <= dly - 1;
        end
        if (sender_start || sender_newline_only) begin
            dly <= 3;
            log_q.push_back({sender_newline_only, sender_is_last_col, sender_data});
            if (!sender_ready) bad_pulse <= bad_pulse + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] el(input logic last, input logic [31:0] d);
        return {30'd0, 1'b0, last, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_q.size() < n && k < 500) begin
            tick(1);
            k++;
        end
        check(tag, 64'(log_q.size() >= n), 64'd1);
    endtask

    task automatic wait_err_done(input string tag);
        int k = 0;
        while (!show_err && k < 50) begin
            tick(1);
            k++;
        end
        k = 0;
        while (show_err && k < 200) begin
            tick(1);
            k++;
        end
        check(tag, 64'(k), 64'(TMO));
    endtask

    initial begin
        int b;
        for (int i = 0; i < 16; i++) begin
            dims_r[i] = 3'd0;
            dims_c[i] = 3'd0;
        end
        for (int i = 0; i < 400; i++) mem[i] = 32'd0;
        rst_n = 1'b0; start_en = 1'b0; rx_data = 8'd0; rx_done = 1'b0;
        mat_count = 4'd0; sender_ready = 1'b1; btn_exit = 1'b0;
        dims_r[0] = 3'd1; dims_c[0] = 3'd1; mem[0] = 32'd7;
        dims_r[1] = 3'd2; dims_c[1] = 3'd3;
        for (int i = 0; i < 6; i++) mem[25 + (i / 3) * 5 + (i % 3)] = 32'(i + 1);

        tick(2);
        check("rst_start", 64'(sender_start), 64'd0);
        check("rst_done", 64'(show_done), 64'd0);
        check("rst_err", 64'(show_err), 64'd0);
        check("rst_rdid", 64'(rd_mat_id), 64'd0);
        check("rst_sdata", 64'(sender_data), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // single 2x3 matrix in slot 1
        start_en = 1'b1; mat_count = 4'd2;
        tick(2);
        b = log_q.size();
        send_byte(8'h02);
        wait_log(b + 6, "s2_wait");
        tick(10);
        check("s2_count", 64'(log_q.size()), 64'(b + 6));
        check("s2_e0", 64'(log_q[b + 0]), el(1'b0, 32'd1));
        check("s2_e1", 64'(log_q[b + 1]), el(1'b0, 32'd2));
        check("s2_e2", 64'(log_q[b + 2]), el(1'b1, 32'd3));
        check("s2_e3", 64'(log_q[b + 3]), el(1'b0, 32'd4));
        check("s2_e4", 64'(log_q[b + 4]), el(1'b0, 32'd5));
        check("s2_e5", 64'(log_q[b + 5]), el(1'b1, 32'd6));

        // show-all: 1x1 then 1x2
        dims_r[1] = 3'd1; dims_c[1] = 3'd2; mem[25] = 32'd8; mem[26] = 32'd9;
        b = log_q.size();
        send_byte(8'h00);
        wait_log(b + 4, "all_wait");
        tick(10);
        check("all_count", 64'(log_q.size()), 64'(b + 4));
        check("all_e0", 64'(log_q[b + 0]), el(1'b1, 32'd7));
        check("all_gap", 64'(log_q[b + 1][33:32]), 64'd2);
        check("all_e1", 64'(log_q[b + 2]), el(1'b0, 32'd8));
        check("all_e2", 64'(log_q[b + 3]), el(1'b1, 32'd9));

        // sender not ready for 50 cycles
        sender_ready = 1'b0;
        b = log_q.size();
        send_byte(8'h01);
        tick(50);
        check("rdy_hold", 64'(log_q.size()), 64'(b));
        check("rdy_data", 64'(sender_data), 64'd7);
        sender_ready = 1'b1;
        wait_log(b + 1, "rdy_wait");
        tick(10);
        check("rdy_e0", 64'(log_q[b]), el(1'b1, 32'd7));
        check("rdy_bad", 64'(bad_pulse), 64'd0);

        // show-all skipping an empty slot
        mat_count = 4'd3;
        dims_r[1] = 3'd0; dims_c[1] = 3'd0;
        dims_r[2] = 3'd1; dims_c[2] = 3'd1; mem[50] = 32'hAB;
        b = log_q.size();
        send_byte(8'h00);
        wait_log(b + 3, "skip_wait");
        tick(10);
        check("skip_count", 64'(log_q.size()), 64'(b + 3));
        check("skip_e0", 64'(log_q[b + 0]), el(1'b1, 32'd7));
        check("skip_gap", 64'(log_q[b + 1][33:32]), 64'd2);
        check("skip_e1", 64'(log_q[b + 2]), el(1'b1, 32'hAB));

        // selector out of range, empty single slot, show-all with no matrices
        b = log_q.size();
        send_byte(8'h05);
        wait_err_done("err_len_sel");
        check("err_nosend", 64'(log_q.size()), 64'(b));
        send_byte(8'h02);
        wait_err_done("err_len_empty");
        mat_count = 4'd0;
        send_byte(8'h00);
        wait_err_done("err_len_zero");
        check("err_nosend2", 64'(log_q.size()), 64'(b));
        mat_count = 4'd3;
        send_byte(8'h01);
        wait_log(b + 1, "after_err_wait");
        tick(10);
        check("after_err_e0", 64'(log_q[b]), el(1'b1, 32'd7));

        // exit button beats a simultaneous selector byte
        b = log_q.size();
        btn_exit = 1'b1;
        send_byte(8'h01);
        btn_exit = 1'b0;
        check("exit_done", 64'(show_done), 64'd1);
        tick(5);
        check("exit_hold", 64'(show_done), 64'd1);
        check("exit_nosend", 64'(log_q.size()), 64'(b));
        start_en = 1'b0;
        tick(1);
        check("exit_idle", 64'(show_done), 64'd0);

        // reset while waiting on the sender
        dims_r[1] = 3'd1; dims_c[1] = 3'd2;
        start_en = 1'b1;
        tick(2);
        b = log_q.size();
        send_byte(8'h02);
        wait_log(b + 1, "rstx_wait");
        check("rstx_pre_id", 64'(rd_mat_id), 64'd1);
        check("rstx_pre_data", 64'(sender_data), 64'd8);
        rst_n = 1'b0;
        #1;
        check("rstx_id", 64'(rd_mat_id), 64'd0);
        check("rstx_data", 64'(sender_data), 64'd0);
        check("rstx_start", 64'(sender_start), 64'd0);
        check("rstx_nl", 64'(sender_newline_only), 64'd0);
        check("rstx_last", 64'(sender_is_last_col), 64'd0);
        check("rstx_done", 64'(show_done), 64'd0);
        check("rstx_err", 64'(show_err), 64'd0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/matrix_show.md
MATRIX_SHOW -- requirements
Module: matrix_show

Interface
REQ-001 Parameters: MAX_ROWS=5 (row limit); MAX_COLS=5 (column limit); MAX_MATS=10 (storage slots); ERR_TIMEOUT_CYCLES=300_000_000 (3 s at 100 MHz).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start_en  in  1  level; mode active while high.
REQ-005 rx_data  in  8  UART byte (matrix selector); rx_done  in  1  one-cycle strobe, rx_data valid.
REQ-006 mat_count  in  4  number of stored matrices, 0..MAX_MATS.
REQ-007 rd_mat_id  out  4  storage read slot, 0-based; rd_row_idx  out  3; rd_col_idx  out  3.
REQ-008 rd_dims_r  in  3; rd_dims_c  in  3  dims of slot rd_mat_id, combinational; rd_data  in  32  element, valid exactly 1 cycle after address change.
REQ-009 sender_data  out  32; sender_start  out  1  pulse; sender_is_last_col  out  1; sender_newline_only  out  1; sender_ready  in  1; sender_done  in  1  pulse.
REQ-010 btn_exit  in  1  level; show_done  out  1; show_err  out  1.

Function
REQ-011 States: IDLE, GET_ID, CHECK, RD_ADDR, RD_WAIT, SEND, TX_WAIT, NEXT_ELEM, SEND_GAP, GAP_WAIT, ERROR, DONE.
REQ-012 IDLE -> GET_ID when start_en=1; row, col and matrix counters cleared in IDLE.
REQ-013 GET_ID: btn_exit=1 -> DONE (priority over rx_done); rx_done -> latch rx_data as sel, -> CHECK.
REQ-014 CHECK (1 cycle): sel=0 with mat_count>0 -> show-all, first slot 0, last slot mat_count-1; 1<=sel<=mat_count -> single, slot sel-1; else -> ERROR.
REQ-015 RD_ADDR: drive rd_mat_id/rd_row_idx/rd_col_idx from counters; -> RD_WAIT next cycle.
REQ-016 RD_WAIT: latch rd_data into sender_data at end of cycle; -> SEND.
REQ-017 SEND: hold until sender_ready=1; that cycle pulse sender_start, sender_newline_only=0; -> TX_WAIT.
REQ-018 sender_is_last_col = (col == rd_dims_c-1), combinational, stable through TX_WAIT.
REQ-019 TX_WAIT: sender_done -> NEXT_ELEM; otherwise hold.
REQ-020 NEXT_ELEM: col<dims_c-1 -> col+1, -> RD_ADDR; else col=0 and row<dims_r-1 -> row+1, -> RD_ADDR; else matrix finished.
REQ-021 Matrix finished: current slot = last slot -> GET_ID; else row=col=0, slot+1, -> SEND_GAP.
REQ-022 SEND_GAP: on sender_ready pulse sender_start with sender_newline_only=1; -> GAP_WAIT; GAP_WAIT: sender_done -> RD_ADDR.
REQ-023 Slot with rd_dims_r=0 or rd_dims_c=0 in show-all: skip (slot+1, or GET_ID if last), no sender traffic; in single mode -> ERROR.
REQ-024 ERROR: show_err=1; timer counts each cycle, saturates at ERR_TIMEOUT_CYCLES; on reaching it -> GET_ID, timer cleared; show_err=0 in all other states.
REQ-025 DONE: show_done=1 each cycle; start_en=0 -> IDLE.
REQ-026 btn_exit ignored outside GET_ID; transfers always complete.
REQ-027 sender_start and sender_newline_only are single-cycle pulses, default 0; never asserted unless sender_ready=1 that cycle.
REQ-028 start_en falling mid-transfer: no abort; exit only via DONE.
REQ-029 Exactly one sender_start per element and per gap; element order row-major.

Reset
REQ-030 rst_n=0: state IDLE; all counters, timer, sel, rd_* outputs, sender_data 0; sender_start, sender_newline_only, show_done, show_err 0; takes effect immediately, mid-transfer included.

Verification
REQ-031 mat_count=2, slot1 2x3 = 1..6, rx 0x02 -> six sender_start, data 1..6, is_last_col on 3rd and 6th, no newline_only pulse, back to GET_ID.
REQ-032 mat_count=2, slots 1x1=7 and 1x2=8,9, rx 0x00 -> data 7, one newline_only pulse, data 8,9.
REQ-033 mat_count=1, rx 0x05 -> show_err high 300_000_000 cycles, no sender_start, then GET_ID.
REQ-034 sender_ready held 0 for 50 cycles in SEND -> no sender_start until ready rises; sender_data stable.
REQ-035 btn_exit=1 in GET_ID -> DONE, show_done=1; start_en=0 -> IDLE; rst_n low mid-TX_WAIT -> all outputs 0 same cycle.
